riscv_run_controller: RTL and testbench
=======================================

# riscv_run_controller

Parametrised run controller for the pipelined RISC-V core; replaces fixed delays in the simulation harness with cycle-accurate sequencing. It:
- sequences the core's reset for a programmable number of cycles;
- lets the program run and detects program end (tohost write, `ecall`, `ebreak`) or a cycle-budget timeout;
- drains the pipeline and then holds a sticky pass/fail verdict with cycle and retire counts.

It sits beside `top_pipelined_riscv`, is driven by the harness clock and reset, and feeds the core's reset input.

## Interface
- `RESET_CYCLES`, 2: cycles `core_reset` stays high after `reset` deasserts; legal range ≥1.
- `MAX_CYCLES`, 100: run-cycle budget before timeout; legal range ≥1 and < 2^`CNT_W`.
- `DRAIN_CYCLES`, 4: cycles waited after a halt event before `done`; 0 allowed.
- `CNT_W`, 32: width of the cycle and retire counters.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `retire_valid`  in  1  one instruction retires this cycle.
- `retire_instr`  in  32  encoding of the retiring instruction.
- `tohost_we`  in  1  store to the tohost address this cycle.
- `tohost_data`  in  32  store data.
- `core_reset`  out  1  reset to the core.
- `running`  out  1  state is RUN.
- `done`  out  1  verdict valid (sticky).
- `pass`  out  1  program passed.
- `timeout`  out  1  ended by budget exhaustion.
- `exit_code`  out  31  tohost data[31:1]; 0 for ecall/ebreak/timeout.
- `cycle_count`  out  `CNT_W`  RUN-state cycles.
- `retire_count`  out  `CNT_W`  retirements in RUN and DRAIN.

## Operation
- States: HOLD → RUN → DRAIN → DONE. `reset` forces HOLD from any state, including mid-run.
- HOLD: `hold_cnt` increments each cycle. When `hold_cnt == RESET_CYCLES-1`, go to RUN.
- RUN: `cycle_count` increments every cycle; `retire_count` increments on `retire_valid`. Halt events, in priority order:
  - `tohost_we` with `tohost_data[0]==1`: `pass = (tohost_data==1)`, `exit_code = tohost_data[31:1]`.
  - `retire_valid` with `retire_instr==32'h00000073` (ecall): pass=1.
  - `retire_valid` with `retire_instr==32'h00100073` (ebreak): pass=0.
  - Next `cycle_count` would equal `MAX_CYCLES` with no halt event this cycle: pass=0, timeout=1.
  - A tohost write with data[0]==0 is ignored.
- The first halt event is latched and the state moves to DRAIN. If `DRAIN_CYCLES==0`, it moves straight to DONE.
- DRAIN: `drain_cnt` counts to `DRAIN_CYCLES`, then DONE. `retire_count` keeps counting. Further halt events are ignored. `cycle_count` is frozen.
- DONE: everything is frozen. `done=1`, and the verdict holds until `reset`.
- Reset values: `core_reset=1`; `running`, `done`, `pass`, `timeout` = 0; `exit_code`, `cycle_count`, `retire_count` = 0.

## Timing
- All outputs are registered. `core_reset` is 1 during `reset` and for exactly `RESET_CYCLES` rising edges after `reset` falls. It falls on the edge that enters RUN.
- `running` rises on the same edge.
- Halt event sampled at edge N: latched verdict is visible after edge N. `done` rises after edge N+`DRAIN_CYCLES`+1.
- Halt and budget exhaustion on the same cycle: the halt wins, timeout=0, and `cycle_count` equals `MAX_CYCLES`.
- Timeout: `cycle_count == MAX_CYCLES` when `done` rises.
- Counters saturate at all-ones and never wrap.
- `reset` asserted mid-RUN or mid-DRAIN: all outputs return to reset values asynchronously, then the HOLD sequence restarts.

## Structure
- Package `riscv_sim_pkg`: state enum (HOLD, RUN, DRAIN, DONE), `INSTR_ECALL = 32'h00000073`, `INSTR_EBREAK = 32'h00100073`.
- One sub-module, `run_counter`:
  - parametrised `W`;
  - ports: `clk`, `reset`, `en`, `q`;
  - saturating; async clear.
  - Instantiated twice, for cycles and retires.
- The hold and drain counters stay inline.

## Test plan
- **Reset sequence:** defaults, `reset` high 2 cycles then low → `core_reset` high for exactly 2 more edges, `running` rises on the 2nd edge, counters 0.
- **tohost pass:** retire 10 instructions, then `tohost_we`, data=1 at run cycle 12 → `done` 5 cycles later, pass=1, exit_code=0, cycle_count=12, retire_count=10 plus any retires during drain.
- **tohost fail:** data=32'h0000_0007 → pass=0, timeout=0, exit_code=3. A later write with data=1 during DRAIN does not change the verdict.
- **ecall/ebreak priority:**
  - ebreak retired alone → pass=0.
  - ecall retired in the same cycle as `tohost_we`, data=5 → tohost wins, pass=0, exit_code=2.
- **Timeout:** `MAX_CYCLES=50`, no halt → timeout=1, pass=0, cycle_count=50.
  - Variant: halt on cycle 50 → timeout=0.
- **Reset mid-run and no drain:**
  - `reset` pulsed at run cycle 20 → outputs cleared immediately, full HOLD restart.
  - `DRAIN_CYCLES=0` → `done` one edge after the halt.

Source files
------------

// File: rtl/riscv_sim_pkg.sv
// Shared types for the simulation run controller: run-phase encoding and halt instruction encodings.
package riscv_sim_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/run_counter.sv
// Saturating up-counter with async clear; advances one per enabled edge, sticks at all-ones.
// Latency: one edge from enable to count; no backpressure.
module run_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/riscv_run_controller.sv
// Core run sequencer: holds core reset, runs until tohost/ecall/ebreak/budget, drains, then latches a sticky verdict.
// Latency: verdict one edge after the halt, done DRAIN_CYCLES+1 edges later; no backpressure.
module riscv_run_controller #(
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 100,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_valid,
    input  logic [31:0]      retire_instr,
    input  logic             tohost_we,
    input  logic [31:0]      tohost_data,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [30:0]      exit_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    import riscv_sim_pkg::*;

    localparam logic [31:0]      HOLD_LAST   = 32'(RESET_CYCLES - 1);
    localparam logic [31:0]      DRAIN_LAST  = 32'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] hold_cnt;
    logic [31:0] drain_cnt;

    logic        halt_tohost;
    logic        halt_ecall;
    logic        halt_ebreak;
    logic        budget_out;
    logic        latch;
    logic        pass_next;
    logic        timeout_next;
    logic [30:0] exit_next;

    assign halt_tohost = tohost_we && tohost_data[0];
    assign halt_ecall  = retire_valid && (retire_instr == INSTR_ECALL);
    assign halt_ebreak = retire_valid && (retire_instr == INSTR_EBREAK);
    assign budget_out  = (cycle_count == BUDGET_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        latch        = 1'b0;
        pass_next    = 1'b0;
        timeout_next = 1'b0;
        exit_next    = '0;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Priority order matters: tohost beats ecall beats ebreak beats the budget.
                if (halt_tohost) begin
                    latch     = 1'b1;
                    pass_next = (tohost_data == 32'd1);
                    exit_next = tohost_data[31:1];
                end else if (halt_ecall) begin
                    latch     = 1'b1;
                    pass_next = 1'b1;
                end else if (halt_ebreak) begin
                    latch     = 1'b1;
                end else if (budget_out) begin
                    latch        = 1'b1;
                    timeout_next = 1'b1;
                end
                if (latch) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = HOLD;
            end
        endcase
    end

    // Status flags are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt   <= '0;
            drain_cnt  <= '0;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            exit_code  <= '0;
        end else begin
            if (state == HOLD) begin
                hold_cnt <= hold_cnt + 32'd1;
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 32'd1;
            end
            core_reset <= (state_next == HOLD);
            running    <= (state_next == RUN);
            done       <= (state_next == DONE);
            if (latch) begin
                pass      <= pass_next;
                timeout   <= timeout_next;
                exit_code <= exit_next;
            end
        end
    end

    run_counter #(.W(CNT_W)) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .en    (state == RUN),
        .q     (cycle_count)
    );

    run_counter #(.W(CNT_W)) u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .en    (retire_valid && ((state == RUN) || (state == DRAIN))),
        .q     (retire_count)
    );

endmodule

// File: tb/tb_riscv_run_controller.sv
// Directed bench: four controller instances with different budgets/drain depths share one stimulus stream.
module tb_riscv_run_controller;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        reset;
    logic        retire_valid;
    logic [31:0] retire_instr;
    logic        tohost_we;
    logic [31:0] tohost_data;

    // a: defaults; t: 50-cycle budget; z: no drain; s: 4-bit counters, 15-cycle budget
    logic a_core_reset, a_running, a_done, a_pass, a_timeout;
    logic t_core_reset, t_running, t_done, t_pass, t_timeout;
    logic z_core_reset, z_running, z_done, z_pass, z_timeout;
    logic s_core_reset, s_running, s_done, s_pass, s_timeout;
    logic [30:0] a_exit, t_exit, z_exit, s_exit;
    logic [31:0] a_cycle, a_retire, t_cycle, t_retire, z_cycle, z_retire;
    logic [3:0]  s_cycle, s_retire;

    int total = 0;
    int bad   = 0;

    riscv_run_controller dut_a (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_instr(retire_instr),
        .tohost_we(tohost_we), .tohost_data(tohost_data), .core_reset(a_core_reset),
        .running(a_running), .done(a_done), .pass(a_pass), .timeout(a_timeout),
        .exit_code(a_exit), .cycle_count(a_cycle), .retire_count(a_retire)
    );

    riscv_run_controller #(.MAX_CYCLES(50)) dut_t (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_instr(retire_instr),
        .tohost_we(tohost_we), .tohost_data(tohost_data), .core_reset(t_core_reset),
        .running(t_running), .done(t_done), .pass(t_pass), .timeout(t_timeout),
        .exit_code(t_exit), .cycle_count(t_cycle), .retire_count(t_retire)
    );

    riscv_run_controller #(.DRAIN_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_instr(retire_instr),
        .tohost_we(tohost_we), .tohost_data(tohost_data), .core_reset(z_core_reset),
        .running(z_running), .done(z_done), .pass(z_pass), .timeout(z_timeout),
        .exit_code(z_exit), .cycle_count(z_cycle), .retire_count(z_retire)
    );

    riscv_run_controller #(.MAX_CYCLES(15), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_instr(retire_instr),
        .tohost_we(tohost_we), .tohost_data(tohost_data), .core_reset(s_core_reset),
        .running(s_running), .done(s_done), .pass(s_pass), .timeout(s_timeout),
        .exit_code(s_exit), .cycle_count(s_cycle), .retire_count(s_retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] instr, input logic we, input logic [31:0] data);
        retire_valid = rv;
        retire_instr = instr;
        tohost_we    = we;
        tohost_data  = data;
    endtask

    // Leaves every instance freshly in RUN with zero counts.
    task automatic do_reset();
        drive(1'b0, NOP, 1'b0, 32'd0);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        drive(1'b0, NOP, 1'b0, 32'd0);
        reset = 1'b1;
        step();
        step();
        total++; if (a_core_reset !== 1'b1) begin bad++; $display("FAIL rst_core_reset got=%0b exp=1", a_core_reset); end
        total++; if ({a_running, a_done, a_pass, a_timeout} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {a_running, a_done, a_pass, a_timeout}); end
        total++; if ({a_exit, a_cycle, a_retire} !== 95'd0) begin bad++; $display("FAIL rst_counts got=%0h exp=0", {a_exit, a_cycle, a_retire}); end
        reset = 1'b0;
        step();
        total++; if ({a_core_reset, a_running} !== 2'b10) begin bad++; $display("FAIL rst_edge1 got=%b exp=10", {a_core_reset, a_running}); end
        step();
        total++; if ({a_core_reset, a_running} !== 2'b01) begin bad++; $display("FAIL rst_edge2 got=%b exp=01", {a_core_reset, a_running}); end
        total++; if (a_cycle !== 32'd0 || a_done !== 1'b0) begin bad++; $display("FAIL rst_run_entry got=%0d/%0b exp=0/0", a_cycle, a_done); end
    endtask

    task automatic test_tohost_pass();
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            if (k <= 10) drive(1'b1, NOP, 1'b0, 32'd0);
            else if (k == 12) drive(1'b0, NOP, 1'b1, 32'd1);
            else drive(1'b0, NOP, 1'b0, 32'd0);
            step();
        end
        total++; if ({a_pass, a_timeout, a_running, a_done} !== 4'b1000) begin bad++; $display("FAIL pass_latch got=%b exp=1000", {a_pass, a_timeout, a_running, a_done}); end
        total++; if (a_cycle !== 32'd12 || a_retire !== 32'd10) begin bad++; $display("FAIL pass_counts got=%0d/%0d exp=12/10", a_cycle, a_retire); end
        total++; if (a_exit !== 31'd0) begin bad++; $display("FAIL pass_exit got=%0d exp=0", a_exit); end
        drive(1'b1, NOP, 1'b0, 32'd0);
        step();
        total++; if (z_done !== 1'b1 || z_pass !== 1'b1) begin bad++; $display("FAIL nodrain_done got=%0b/%0b exp=1/1", z_done, z_pass); end
        step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        step();
        step();
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL pass_done_early got=%0b exp=0", a_done); end
        step();
        total++; if (a_done !== 1'b1 || a_pass !== 1'b1) begin bad++; $display("FAIL pass_done got=%0b/%0b exp=1/1", a_done, a_pass); end
        total++; if (a_retire !== 32'd12 || a_cycle !== 32'd12) begin bad++; $display("FAIL pass_drain_counts got=%0d/%0d exp=12/12", a_retire, a_cycle); end
        drive(1'b1, NOP, 1'b0, 32'd0);
        step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        total++; if (a_retire !== 32'd12 || a_done !== 1'b1) begin bad++; $display("FAIL pass_frozen got=%0d/%0b exp=12/1", a_retire, a_done); end
    endtask

    task automatic test_tohost_fail();
        do_reset();
        step();
        step();
        drive(1'b0, NOP, 1'b1, 32'h4);
        step();
        total++; if (a_running !== 1'b1) begin bad++; $display("FAIL even_tohost_ignored got=%0b exp=1", a_running); end
        drive(1'b0, NOP, 1'b1, 32'h7);
        step();
        total++; if ({a_pass, a_timeout, a_running} !== 3'b000 || a_exit !== 31'd3) begin bad++; $display("FAIL fail_latch got=%b exit=%0d exp=000 exit=3", {a_pass, a_timeout, a_running}, a_exit); end
        drive(1'b0, NOP, 1'b1, 32'h1);
        step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        total++; if (a_pass !== 1'b0 || a_exit !== 31'd3) begin bad++; $display("FAIL fail_drain_write got=%0b/%0d exp=0/3", a_pass, a_exit); end
        repeat (4) step();
        total++; if ({a_done, a_pass, a_timeout} !== 3'b100 || a_exit !== 31'd3 || a_cycle !== 32'd4) begin bad++; $display("FAIL fail_done got=%b exit=%0d cyc=%0d exp=100 exit=3 cyc=4", {a_done, a_pass, a_timeout}, a_exit, a_cycle); end
    endtask

    task automatic test_priority();
        do_reset();
        step();
        drive(1'b1, EBREAK, 1'b0, 32'd0);
        step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        total++; if ({a_pass, a_timeout, a_running} !== 3'b000 || a_exit !== 31'd0) begin bad++; $display("FAIL ebreak_latch got=%b exit=%0d exp=000 exit=0", {a_pass, a_timeout, a_running}, a_exit); end
        repeat (5) step();
        total++; if (a_done !== 1'b1 || a_pass !== 1'b0) begin bad++; $display("FAIL ebreak_done got=%0b/%0b exp=1/0", a_done, a_pass); end
        do_reset();
        drive(1'b1, ECALL, 1'b1, 32'd5);
        step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        total++; if (a_pass !== 1'b0 || a_exit !== 31'd2 || a_running !== 1'b0) begin bad++; $display("FAIL tohost_over_ecall got=%0b/%0d/%0b exp=0/2/0", a_pass, a_exit, a_running); end
        do_reset();
        drive(1'b1, ECALL, 1'b0, 32'd0);
        step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        total++; if (a_pass !== 1'b1 || a_exit !== 31'd0 || a_retire !== 32'd1) begin bad++; $display("FAIL ecall_pass got=%0b/%0d/%0d exp=1/0/1", a_pass, a_exit, a_retire); end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (49) step();
        total++; if (t_running !== 1'b1 || t_cycle !== 32'd49) begin bad++; $display("FAIL to_before got=%0b/%0d exp=1/49", t_running, t_cycle); end
        step();
        total++; if ({t_running, t_timeout, t_pass} !== 3'b010 || t_cycle !== 32'd50) begin bad++; $display("FAIL to_latch got=%b cyc=%0d exp=010 cyc=50", {t_running, t_timeout, t_pass}, t_cycle); end
        repeat (5) step();
        total++; if (t_done !== 1'b1 || t_cycle !== 32'd50 || t_timeout !== 1'b1) begin bad++; $display("FAIL to_done got=%0b/%0d/%0b exp=1/50/1", t_done, t_cycle, t_timeout); end
        do_reset();
        repeat (49) step();
        drive(1'b1, ECALL, 1'b0, 32'd0);
        step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        total++; if ({t_timeout, t_pass} !== 2'b01 || t_cycle !== 32'd50) begin bad++; $display("FAIL to_halt_wins got=%b cyc=%0d exp=01 cyc=50", {t_timeout, t_pass}, t_cycle); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, NOP, 1'b0, 32'd0);
        repeat (14) step();
        total++; if (s_retire !== 4'd14 || s_running !== 1'b1) begin bad++; $display("FAIL sat_before got=%0d/%0b exp=14/1", s_retire, s_running); end
        step();
        total++; if (s_timeout !== 1'b1 || s_cycle !== 4'd15 || s_retire !== 4'd15) begin bad++; $display("FAIL sat_timeout got=%0b/%0d/%0d exp=1/15/15", s_timeout, s_cycle, s_retire); end
        repeat (5) step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        total++; if (s_done !== 1'b1 || s_retire !== 4'd15 || s_cycle !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0b/%0d/%0d exp=1/15/15", s_done, s_retire, s_cycle); end
        total++; if (a_retire !== 32'd20 || a_running !== 1'b1) begin bad++; $display("FAIL sat_wide_ref got=%0d/%0b exp=20/1", a_retire, a_running); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        drive(1'b1, NOP, 1'b0, 32'd0);
        repeat (20) step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        total++; if (a_cycle !== 32'd20 || a_retire !== 32'd20) begin bad++; $display("FAIL mid_before got=%0d/%0d exp=20/20", a_cycle, a_retire); end
        reset = 1'b1;
        #1;
        total++; if ({a_core_reset, a_running, a_done} !== 3'b100 || a_cycle !== 32'd0 || a_retire !== 32'd0) begin bad++; $display("FAIL mid_async got=%b cyc=%0d ret=%0d exp=100 0 0", {a_core_reset, a_running, a_done}, a_cycle, a_retire); end
        step();
        reset = 1'b0;
        step();
        total++; if ({a_core_reset, a_running} !== 2'b10) begin bad++; $display("FAIL mid_hold got=%b exp=10", {a_core_reset, a_running}); end
        step();
        total++; if ({a_core_reset, a_running} !== 2'b01 || a_cycle !== 32'd0) begin bad++; $display("FAIL mid_restart got=%b cyc=%0d exp=01 cyc=0", {a_core_reset, a_running}, a_cycle); end
        drive(1'b1, ECALL, 1'b0, 32'd0);
        step();
        drive(1'b0, NOP, 1'b0, 32'd0);
        step();
        reset = 1'b1;
        #1;
        total++; if ({a_core_reset, a_pass, a_done, a_running} !== 4'b1000) begin bad++; $display("FAIL drain_async got=%b exp=1000", {a_core_reset, a_pass, a_done, a_running}); end
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, NOP, 1'b0, 32'd0);
        test_reset();
        test_tohost_pass();
        test_tohost_fail();
        test_priority();
        test_timeout();
        test_saturation();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
